filter_pair_scheduler: RTL and testbench
========================================

# filter_pair_scheduler

Sequences candidate (reference, neighbor) particle pairs for one home cell into the pair-filter datapath. It walks every home-cell particle against every particle of the home cell and its half-shell neighbor cells, and issues cell-memory read addresses with backpressure. It tags each returned pair with its cell IDs and signals completion of the sweep. It sits between the sweep controller (start/done) and the cell particle memories, whose 106-bit outputs feed the filter directly.

## Interface
- ADDR_W, 8, particle index width within a cell
- CELL_W, 8, cell ID width
- N_NBR, 14, cells per sweep; slot 0 is the home cell
- fast_clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin sweep; sampled only in IDLE
- cell_ids  in  CELL_W*N_NBR  cell ID per slot k at [k*CELL_W+:CELL_W]; latched at start
- cell_counts  in  (ADDR_W+1)*N_NBR  particle count per slot, 0..2^ADDR_W; latched at start
- stall  in  1  downstream backpressure; no new read issued at an edge where high
- rd_en  out  1  read strobe to cell memories
- rd_ref_cell  out  CELL_W  home cell ID (slot 0)
- rd_ref_idx  out  ADDR_W  reference particle index
- rd_nbr_cell  out  CELL_W  neighbor cell ID (slot k)
- rd_nbr_idx  out  ADDR_W  neighbor particle index
- pair_valid  out  1  memory data for a pair is on the filter inputs this cycle
- reference_cell  out  CELL_W  cell tag aligned with pair_valid
- neighbor_cell  out  CELL_W  cell tag aligned with pair_valid
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

## Operation
- States:
  - IDLE: start=1 latches cell_ids and cell_counts and goes to LOAD.
  - LOAD: computes the first slot k with a nonzero count. If count[0]==0 or no slot has a nonzero count, goes to DONE. Otherwise sets i=0, j=0 and goes to ISSUE.
  - ISSUE: issues pairs, advancing on each issued pair.
  - DRAIN: one cycle for the last read to return.
  - DONE: done=1 for one cycle, then IDLE.
- Loop order:
  - outer: slot k, ascending, skipping slots with count 0
  - middle: reference index i, 0..count[0]-1
  - inner: neighbor index j, 0..count[k]-1
- Empty-slot skip costs zero cycles. The next slot is a combinational find-next-nonzero over the latched counts above k. No slot found after the last pair means ISSUE goes to DRAIN.
- All pairs are issued, including i==j in slot 0. Self-pair and N3L rejection belong to the filter.
- Total pairs per sweep = count[0] * sum over k of count[k]. Counts are (ADDR_W+1) bits, so 256 is legal with ADDR_W=8.
- Index width: j and i wrap from count-1 to 0. Counters never exceed count-1.
- start outside IDLE is ignored. cell_ids and cell_counts changes after latch are ignored.
- reset at any point: next edge forces IDLE and clears all outputs. An in-flight pair_valid is dropped.

## Timing
- All outputs are registered. After reset every output is 0.
- Sweep timeline, with edge E0 the edge that samples start=1:
  - After E0: LOAD, busy=1.
  - After E1: first issue, rd_en=1 with (i=0, j=0, first nonzero k).
- Memories register addresses on the rising edge, one-cycle read latency. pair_valid, reference_cell and neighbor_cell equal rd_en, rd_ref_cell and rd_nbr_cell delayed one edge.
- stall:
  - stall=1 sampled at an edge means rd_en=0 after that edge, and i/j/k and the rd_* addresses hold.
  - Issue resumes after the first edge that samples stall=0.
  - A read already issued still produces its pair_valid.
- When no stall occurs, rd_en stays high for P consecutive cycles, where P is the pair count.
- End of sweep:
  - The last pair_valid is in DRAIN.
  - done=1 and busy=0 after the following edge.
  - The state is IDLE one edge later. start is accepted from IDLE on that edge.
- Empty sweep: done=1 and busy=0 after E1. rd_en and pair_valid never assert.
- rd_* and tag outputs hold their last values while rd_en and pair_valid are low.

## Test plan
- count[0]=2, count[1]=3, others 0, no stall:
  - rd_en high after E1..E10.
  - Pair order: (0,0,s0), (0,1,s0), (1,0,s0), (1,1,s0), then (0,0..2,s1), then (1,0..2,s1).
  - pair_valid high after E2..E11; done after E12.
- count[0]=0 with other counts nonzero: done pulse after E1, zero rd_en cycles, busy high exactly one cycle.
- count[0]=1, count[5]=1, count[13]=2, slots 1-4 and 6-12 empty:
  - 4 pairs on consecutive cycles with k=0,5,13,13.
  - No bubble cycles.
- Stall handling, 10-pair sweep from the first test:
  - stall held high for 3 edges after the third issue: rd_en low exactly 3 cycles.
  - Pair sequence unchanged; done 3 cycles later (after E15).
- reset asserted mid-sweep after E5: all outputs 0 next cycle. A new start then produces a full, correct 10-pair sweep.
- start pulsed again during busy: ignored. The sweep and done timing are identical to the first test.

Source files
------------

// File: rtl/filter_pair_scheduler.sv
// Walks every home-cell particle against every particle of the home and half-shell
// neighbor cells, issuing cell-memory reads with backpressure and tagging returned pairs.
module filter_pair_scheduler #(
    parameter int ADDR_W = 8,
    parameter int CELL_W = 8,
    parameter int N_NBR  = 14
) (
    input  logic                          fast_clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CELL_W*N_NBR-1:0]       cell_ids,
    input  logic [(ADDR_W+1)*N_NBR-1:0]   cell_counts,
    input  logic                          stall,
    output logic                          rd_en,
    output logic [CELL_W-1:0]             rd_ref_cell,
    output logic [ADDR_W-1:0]             rd_ref_idx,
    output logic [CELL_W-1:0]             rd_nbr_cell,
    output logic [ADDR_W-1:0]             rd_nbr_idx,
    output logic                          pair_valid,
    output logic [CELL_W-1:0]             reference_cell,
    output logic [CELL_W-1:0]             neighbor_cell,
    output logic                          busy,
    output logic                          done
);

    localparam int KW = (N_NBR > 1) ? $clog2(N_NBR) : 1;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [CELL_W-1:0] id_q  [N_NBR];
    logic [ADDR_W:0]   cnt_q [N_NBR];
    logic [KW-1:0]     slot_k;

    logic [KW-1:0]     next_k;
    logic              next_found;
    logic              j_last;
    logic              i_last;

    // Zero-cycle skip of empty slots: first nonzero slot strictly above the current one.
    always_comb begin
        next_k     = slot_k;
        next_found = 1'b0;
        for (int s = 0; s < N_NBR; s++) begin
            if (!next_found && (KW'(s) > slot_k) && (cnt_q[s] != '0)) begin
                next_found = 1'b1;
                next_k     = KW'(s);
            end
        end
    end

    assign j_last = ({1'b0, rd_nbr_idx} + CNT_ONE) >= cnt_q[slot_k];
    assign i_last = ({1'b0, rd_ref_idx} + CNT_ONE) >= cnt_q[0];

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            state          <= IDLE;
            slot_k         <= '0;
            rd_en          <= 1'b0;
            rd_ref_cell    <= '0;
            rd_ref_idx     <= '0;
            rd_nbr_cell    <= '0;
            rd_nbr_idx     <= '0;
            pair_valid     <= 1'b0;
            reference_cell <= '0;
            neighbor_cell  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            // Read-return stage: memory data lands on the filter one edge after rd_en.
            pair_valid <= rd_en;
            if (rd_en) begin
                reference_cell <= rd_ref_cell;
                neighbor_cell  <= rd_nbr_cell;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int s = 0; s < N_NBR; s++) begin
                            id_q[s]  <= cell_ids[s*CELL_W +: CELL_W];
                            cnt_q[s] <= cell_counts[s*(ADDR_W+1) +: (ADDR_W+1)];
                        end
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Slot 0 is the first nonzero slot whenever the home cell is non-empty.
                    if (cnt_q[0] == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!stall) begin
                        slot_k      <= '0;
                        rd_en       <= 1'b1;
                        rd_ref_idx  <= '0;
                        rd_nbr_idx  <= '0;
                        rd_ref_cell <= id_q[0];
                        rd_nbr_cell <= id_q[0];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (j_last && i_last && !next_found) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else if (stall) begin
                        rd_en <= 1'b0;
                    end else begin
                        rd_en <= 1'b1;
                        if (!j_last) begin
                            rd_nbr_idx <= rd_nbr_idx + ADDR_W'(1);
                        end else begin
                            rd_nbr_idx <= '0;
                            if (!i_last) begin
                                rd_ref_idx <= rd_ref_idx + ADDR_W'(1);
                            end else begin
                                rd_ref_idx  <= '0;
                                slot_k      <= next_k;
                                rd_nbr_cell <= id_q[next_k];
                            end
                        end
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_pair_scheduler.sv
// Scoreboard bench: the driver pushes the expected per-cycle outputs derived from a
// pair list and an issue counter; a negedge monitor pops and compares.
module tb_filter_pair_scheduler;

    localparam int ADDR_W = 8;
    localparam int CELL_W = 8;
    localparam int N_NBR  = 14;

    logic                        fast_clk = 1'b0;
    logic                        reset, start, stall;
    logic [CELL_W*N_NBR-1:0]     cell_ids;
    logic [(ADDR_W+1)*N_NBR-1:0] cell_counts;
    logic                        rd_en, pair_valid, busy, done;
    logic [CELL_W-1:0]           rd_ref_cell, rd_nbr_cell, reference_cell, neighbor_cell;
    logic [ADDR_W-1:0]           rd_ref_idx, rd_nbr_idx;

    filter_pair_scheduler #(.ADDR_W(ADDR_W), .CELL_W(CELL_W), .N_NBR(N_NBR)) dut (
        .fast_clk(fast_clk), .reset(reset), .start(start), .cell_ids(cell_ids),
        .cell_counts(cell_counts), .stall(stall), .rd_en(rd_en), .rd_ref_cell(rd_ref_cell),
        .rd_ref_idx(rd_ref_idx), .rd_nbr_cell(rd_nbr_cell), .rd_nbr_idx(rd_nbr_idx),
        .pair_valid(pair_valid), .reference_cell(reference_cell),
        .neighbor_cell(neighbor_cell), .busy(busy), .done(done)
    );

    always #5 fast_clk = ~fast_clk;

    typedef struct packed {
        logic [CELL_W-1:0] rc;
        logic [ADDR_W-1:0] ri;
        logic [CELL_W-1:0] nc;
        logic [ADDR_W-1:0] ni;
    } pair_t;

    typedef struct packed {
        logic  rd;
        pair_t p;
        logic  pv;
        pair_t t;
        logic  dn;
        logic  bz;
        logic  zero;
    } exp_t;

    exp_t  exp_q[$];
    int    tests = 0;
    int    failed = 0;
    int    cnt_a[N_NBR];
    logic [CELL_W-1:0] id_a[N_NBR];
    logic  prev_rd = 1'b0;
    pair_t prev_p = '0;
    pair_t no_pair = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge fast_clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("rd_en", 32'(rd_en), 32'(x.rd));
                if (x.rd || x.zero) begin
                    chk("rd_ref_cell", 32'(rd_ref_cell), 32'(x.p.rc));
                    chk("rd_ref_idx",  32'(rd_ref_idx),  32'(x.p.ri));
                    chk("rd_nbr_cell", 32'(rd_nbr_cell), 32'(x.p.nc));
                    chk("rd_nbr_idx",  32'(rd_nbr_idx),  32'(x.p.ni));
                end
                chk("pair_valid", 32'(pair_valid), 32'(x.pv));
                if (x.pv || x.zero) begin
                    chk("reference_cell", 32'(reference_cell), 32'(x.t.rc));
                    chk("neighbor_cell",  32'(neighbor_cell),  32'(x.t.nc));
                end
                chk("done", 32'(done), 32'(x.dn));
                chk("busy", 32'(busy), 32'(x.bz));
            end
        end
    end

    function automatic exp_t mk(input logic rd, input pair_t p, input logic dn, input logic bz);
        exp_t x;
        x.rd = rd; x.p = p; x.pv = prev_rd; x.t = prev_p;
        x.dn = dn; x.bz = bz; x.zero = 1'b0;
        prev_rd = rd;
        if (rd) prev_p = p;
        return x;
    endfunction

    task automatic tick(input exp_t e);
        @(posedge fast_clk);
        exp_q.push_back(e);
        @(negedge fast_clk);
    endtask

    task automatic tick_reset();
        exp_t z;
        z = '0;
        z.zero = 1'b1;
        prev_rd = 1'b0;
        prev_p  = '0;
        tick(z);
    endtask

    function automatic logic pick_stall(input int mode, input int e);
        if (mode == 1) return ($urandom_range(0, 9) < 3);
        if (mode == 2) return (e >= 4 && e <= 6);
        return 1'b0;
    endfunction

    // stall_mode: 0 none, 1 random, 2 high at edges E4..E6; reset_edge < 0 means none.
    task automatic run_sweep(input int stall_mode, input bit restart, input int reset_edge);
        pair_t pl[$];
        pair_t pr;
        int issued;
        int e;
        for (int k = 0; k < N_NBR; k++)
            if (cnt_a[k] != 0)
                for (int i = 0; i < cnt_a[0]; i++)
                    for (int j = 0; j < cnt_a[k]; j++) begin
                        pr.rc = id_a[0]; pr.ri = ADDR_W'(i);
                        pr.nc = id_a[k]; pr.ni = ADDR_W'(j);
                        pl.push_back(pr);
                    end
        for (int k = 0; k < N_NBR; k++) begin
            cell_ids[k*CELL_W +: CELL_W] = id_a[k];
            cell_counts[k*(ADDR_W+1) +: (ADDR_W+1)] = (ADDR_W+1)'(cnt_a[k]);
        end
        start = 1'b1;
        stall = pick_stall(stall_mode, 0);
        tick(mk(1'b0, no_pair, 1'b0, 1'b1));
        // Later changes to the inputs must be ignored.
        cell_ids    = {N_NBR{CELL_W'($urandom)}};
        cell_counts = '1;
        issued = 0;
        e = 1;
        if (pl.size() == 0) begin
            start = restart ? 1'($urandom_range(0, 1)) : 1'b0;
            stall = pick_stall(stall_mode, 1);
            tick(mk(1'b0, no_pair, 1'b1, 1'b0));
        end else begin
            while (issued < pl.size()) begin
                start = restart ? 1'($urandom_range(0, 1)) : 1'b0;
                stall = pick_stall(stall_mode, e);
                if (e == reset_edge) begin
                    reset = 1'b1;
                    tick_reset();
                    reset = 1'b0;
                    start = 1'b0;
                    stall = 1'b0;
                    return;
                end
                if (!stall) begin
                    tick(mk(1'b1, pl[issued], 1'b0, 1'b1));
                    issued++;
                end else begin
                    tick(mk(1'b0, no_pair, 1'b0, 1'b1));
                end
                e++;
            end
            start = 1'b0;
            stall = pick_stall(stall_mode, e);
            tick(mk(1'b0, no_pair, 1'b0, 1'b1));
            stall = pick_stall(stall_mode, e + 1);
            tick(mk(1'b0, no_pair, 1'b1, 1'b0));
        end
        start = 1'b0;
        stall = 1'b0;
        tick(mk(1'b0, no_pair, 1'b0, 1'b0));
    endtask

    task automatic set_counts_zero();
        for (int k = 0; k < N_NBR; k++) begin
            cnt_a[k] = 0;
            id_a[k]  = CELL_W'(8'h10 + k);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        cell_ids = '0; cell_counts = '0;
        tick_reset();
        tick_reset();
        reset = 1'b0;
        tick(mk(1'b0, no_pair, 1'b0, 1'b0));

        // Basic 10-pair sweep.
        set_counts_zero(); cnt_a[0] = 2; cnt_a[1] = 3;
        run_sweep(0, 1'b0, -1);
        // Empty home cell.
        set_counts_zero(); cnt_a[1] = 3; cnt_a[7] = 2;
        run_sweep(0, 1'b0, -1);
        // Sparse slots with zero-cycle skips.
        set_counts_zero(); cnt_a[0] = 1; cnt_a[5] = 1; cnt_a[13] = 2;
        run_sweep(0, 1'b0, -1);
        // Three-edge stall after the third issue.
        set_counts_zero(); cnt_a[0] = 2; cnt_a[1] = 3;
        run_sweep(2, 1'b0, -1);
        // Reset mid-sweep, then a full sweep.
        run_sweep(0, 1'b0, 6);
        run_sweep(0, 1'b0, -1);
        // Start pulses while busy.
        run_sweep(0, 1'b1, -1);
        // Full-range neighbor count (256) followed by the last slot.
        set_counts_zero(); cnt_a[0] = 1; cnt_a[3] = 256; cnt_a[13] = 1;
        run_sweep(1, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < N_NBR; k++) begin
                id_a[k]  = CELL_W'($urandom);
                cnt_a[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            end
            cnt_a[0] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            run_sweep(($urandom_range(0, 3) == 0) ? 0 : 1, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 12)) : -1);
        end

        tick(mk(1'b0, no_pair, 1'b0, 1'b0));
        @(negedge fast_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
